fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: scalar aliases, the fetch FSM
// state encoding, the default reset PC and a small alignment helper.
package fetch_unit_pkg;

    typedef logic [31:0] i32;
    typedef logic        i1;

    localparam i32 RESET_PC_DEFAULT = 32'hbfc0_0000;

    // REQ/WAIT carry a live transaction, HOLD presents a result to decode,
    // DROP_* drain a transaction whose data must be thrown away.
    typedef enum logic [2:0] {
        ST_REQ       = 3'd0,
        ST_WAIT      = 3'd1,
        ST_HOLD      = 3'd2,
        ST_DROP_REQ  = 3'd3,
        ST_DROP_WAIT = 3'd4
    } fetch_state_e;

    // A fetch address is legal only on a word boundary.
    function automatic i1 is_aligned(input i32 addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-bus handshake between the fetch unit (master) and memory (slave).
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    i1  ireq_valid;
    i32 ireq_addr;
    i1  iresp_addr_ok;
    i1  iresp_data_ok;
    i32 iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_addr_ok,
        input  iresp_data_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_addr_ok,
        output iresp_data_ok,
        output iresp_data
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one read at a time on the instruction bus,
// presents each fetched word to decode until it is taken, and handles PC
// redirects by draining any in-flight transaction without forwarding it.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter i32 RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         resetn,
    fetch_unit_if.master ibus,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         out_valid,
    output logic [31:0]  out_pc,
    output logic [31:0]  out_instr,
    output logic         out_adel
);

    fetch_state_e state;
    i32           pc;
    i32           req_addr;
    i1            req_aligned;

    assign req_aligned = is_aligned(req_addr);

    // A misaligned address never reaches the bus; DROP_REQ keeps an already
    // issued (hence aligned) request asserted until the bus accepts it.
    assign ibus.ireq_valid = ((state == ST_REQ) && req_aligned) || (state == ST_DROP_REQ);
    assign ibus.ireq_addr  = req_addr;

    // Fetch FSM: redirect first, otherwise normal request/response/hold flow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_REQ;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_instr <= '0;
            out_adel  <= 1'b0;
        end else if (redirect_valid) begin
            // The redirect target becomes the next fetch; anything in flight
            // must still complete on the bus but its data is discarded.
            pc        <= redirect_pc;
            out_valid <= 1'b0;
            case (state)
                ST_REQ: begin
                    if (req_aligned && ibus.iresp_addr_ok && !ibus.iresp_data_ok) begin
                        state <= ST_DROP_WAIT;
                    end else if (req_aligned && !ibus.iresp_addr_ok) begin
                        state <= ST_DROP_REQ;
                    end else begin
                        state    <= ST_REQ;
                        req_addr <= redirect_pc;
                    end
                end
                ST_WAIT: begin
                    if (ibus.iresp_data_ok) begin
                        state    <= ST_REQ;
                        req_addr <= redirect_pc;
                    end else begin
                        state <= ST_DROP_WAIT;
                    end
                end
                ST_HOLD: begin
                    state    <= ST_REQ;
                    req_addr <= redirect_pc;
                end
                ST_DROP_REQ: begin
                    if (ibus.iresp_addr_ok && ibus.iresp_data_ok) begin
                        state    <= ST_REQ;
                        req_addr <= redirect_pc;
                    end else if (ibus.iresp_addr_ok) begin
                        state <= ST_DROP_WAIT;
                    end
                end
                ST_DROP_WAIT: begin
                    if (ibus.iresp_data_ok) begin
                        state    <= ST_REQ;
                        req_addr <= redirect_pc;
                    end
                end
                default: begin
                    state    <= ST_REQ;
                    req_addr <= redirect_pc;
                end
            endcase
        end else begin
            case (state)
                ST_REQ: begin
                    if (!req_aligned) begin
                        // Address error: report AdEL with a nop, no bus cycle.
                        out_valid <= 1'b1;
                        out_pc    <= req_addr;
                        out_instr <= '0;
                        out_adel  <= 1'b1;
                        pc        <= pc + 32'd4;
                        state     <= ST_HOLD;
                    end else if (ibus.iresp_addr_ok && ibus.iresp_data_ok) begin
                        out_valid <= 1'b1;
                        out_pc    <= req_addr;
                        out_instr <= ibus.iresp_data;
                        out_adel  <= 1'b0;
                        pc        <= pc + 32'd4;
                        state     <= ST_HOLD;
                    end else if (ibus.iresp_addr_ok) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ibus.iresp_data_ok) begin
                        out_valid <= 1'b1;
                        out_pc    <= req_addr;
                        out_instr <= ibus.iresp_data;
                        out_adel  <= 1'b0;
                        pc        <= pc + 32'd4;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // No new request until decode has taken the entry.
                    if (!stall) begin
                        out_valid <= 1'b0;
                        req_addr  <= pc;
                        state     <= ST_REQ;
                    end
                end
                ST_DROP_REQ: begin
                    if (ibus.iresp_addr_ok && ibus.iresp_data_ok) begin
                        req_addr <= pc;
                        state    <= ST_REQ;
                    end else if (ibus.iresp_addr_ok) begin
                        state <= ST_DROP_WAIT;
                    end
                end
                ST_DROP_WAIT: begin
                    if (ibus.iresp_data_ok) begin
                        req_addr <= pc;
                        state    <= ST_REQ;
                    end
                end
                default: begin
                    req_addr <= pc;
                    state    <= ST_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: drives the instruction bus by hand and
// compares outputs against hand-computed values one cycle at a time.
module tb_fetch_unit;

    logic        clk;
    logic        resetn;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_adel;

    int checks = 0;
    int errors = 0;

    fetch_unit_if ibus ();

    fetch_unit #(.RESET_PC(32'hbfc0_0000)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ibus           (ibus.master),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_adel       (out_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive the bus-response inputs.
    task automatic bus(input logic a, input logic d, input logic [31:0] data);
        ibus.iresp_addr_ok = a;
        ibus.iresp_data_ok = d;
        ibus.iresp_data    = data;
    endtask

    task automatic do_reset;
        resetn         = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bus(1'b0, 1'b0, '0);
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %h want 00000000", out_pc); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %h want 00000000", out_instr); end
        checks++; if (out_adel !== 1'b0) begin errors++; $display("FAIL reset_out_adel: got %b want 0", out_adel); end
        checks++; if (ibus.ireq_valid !== 1'b1) begin errors++; $display("FAIL reset_ireq_valid: got %b want 1", ibus.ireq_valid); end
        checks++; if (ibus.ireq_addr !== 32'hbfc0_0000) begin errors++; $display("FAIL reset_ireq_addr: got %h want bfc00000", ibus.ireq_addr); end
    endtask

    task automatic test_basic_fetch;
        bus(1'b1, 1'b0, '0);
        tick();  // REQ -> WAIT
        checks++; if (ibus.ireq_valid !== 1'b0) begin errors++; $display("FAIL wait_ireq_valid: got %b want 0", ibus.ireq_valid); end
        bus(1'b0, 1'b1, 32'h2408_0001);
        tick();  // WAIT -> HOLD
        bus(1'b0, 1'b0, '0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
        checks++; if (out_pc !== 32'hbfc0_0000) begin errors++; $display("FAIL basic_out_pc: got %h want bfc00000", out_pc); end
        checks++; if (out_instr !== 32'h2408_0001) begin errors++; $display("FAIL basic_out_instr: got %h want 24080001", out_instr); end
        checks++; if (out_adel !== 1'b0) begin errors++; $display("FAIL basic_out_adel: got %b want 0", out_adel); end
        tick();  // HOLD -> REQ
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_taken_valid: got %b want 0", out_valid); end
        checks++; if (ibus.ireq_valid !== 1'b1) begin errors++; $display("FAIL basic_next_req: got %b want 1", ibus.ireq_valid); end
        checks++; if (ibus.ireq_addr !== 32'hbfc0_0004) begin errors++; $display("FAIL basic_next_addr: got %h want bfc00004", ibus.ireq_addr); end
    endtask

    task automatic test_stall;
        do_reset();
        bus(1'b1, 1'b1, 32'haaaa_5555);
        stall = 1'b1;
        tick();  // same-cycle addr_ok & data_ok -> HOLD
        bus(1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'hbfc0_0000 || out_instr !== 32'haaaa_5555)
                begin errors++; $display("FAIL stall_hold_%0d: got v=%b pc=%h instr=%h want v=1 pc=bfc00000 instr=aaaa5555", i, out_valid, out_pc, out_instr); end
            checks++; if (ibus.ireq_valid !== 1'b0) begin errors++; $display("FAIL stall_no_req_%0d: got %b want 0", i, ibus.ireq_valid); end
        end
        stall = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid: got %b want 0", out_valid); end
        checks++; if (ibus.ireq_valid !== 1'b1 || ibus.ireq_addr !== 32'hbfc0_0004)
            begin errors++; $display("FAIL stall_release_req: got v=%b addr=%h want v=1 addr=bfc00004", ibus.ireq_valid, ibus.ireq_addr); end
    endtask

    task automatic test_redirect_wait;
        bus(1'b1, 1'b0, '0);
        tick();  // REQ -> WAIT
        bus(1'b0, 1'b0, '0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hbfc0_0100;
        tick();  // WAIT + redirect -> DROP_WAIT
        redirect_valid = 1'b0;
        checks++; if (ibus.ireq_valid !== 1'b0) begin errors++; $display("FAIL rw_drop_req: got %b want 0", ibus.ireq_valid); end
        bus(1'b0, 1'b1, 32'hdead_beef);
        tick();  // dropped data, -> REQ
        bus(1'b0, 1'b0, '0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rw_dropped_valid: got %b want 0", out_valid); end
        checks++; if (ibus.ireq_valid !== 1'b1 || ibus.ireq_addr !== 32'hbfc0_0100)
            begin errors++; $display("FAIL rw_target_req: got v=%b addr=%h want v=1 addr=bfc00100", ibus.ireq_valid, ibus.ireq_addr); end
        bus(1'b1, 1'b1, 32'h1111_1111);
        tick();
        bus(1'b0, 1'b0, '0);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'hbfc0_0100 || out_instr !== 32'h1111_1111)
            begin errors++; $display("FAIL rw_target_out: got v=%b pc=%h instr=%h want v=1 pc=bfc00100 instr=11111111", out_valid, out_pc, out_instr); end
        tick();  // HOLD -> REQ at bfc00104
    endtask

    task automatic test_misaligned;
        bus(1'b1, 1'b1, 32'h5a5a_5a5a);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hbfc0_0102;
        tick();  // coincident data discarded, REQ at bfc00102
        redirect_valid = 1'b0;
        bus(1'b0, 1'b0, '0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mis_discard_valid: got %b want 0", out_valid); end
        checks++; if (ibus.ireq_valid !== 1'b0) begin errors++; $display("FAIL mis_no_req: got %b want 0", ibus.ireq_valid); end
        tick();  // AdEL capture
        checks++; if (out_valid !== 1'b1 || out_adel !== 1'b1 || out_instr !== 32'h0 || out_pc !== 32'hbfc0_0102)
            begin errors++; $display("FAIL mis_capture: got v=%b adel=%b instr=%h pc=%h want v=1 adel=1 instr=00000000 pc=bfc00102", out_valid, out_adel, out_instr, out_pc); end
        checks++; if (ibus.ireq_valid !== 1'b0) begin errors++; $display("FAIL mis_hold_req: got %b want 0", ibus.ireq_valid); end
        tick();  // HOLD -> REQ at bfc00106, still misaligned
        checks++; if (ibus.ireq_valid !== 1'b0 || ibus.ireq_addr !== 32'hbfc0_0106)
            begin errors++; $display("FAIL mis_next: got v=%b addr=%h want v=0 addr=bfc00106", ibus.ireq_valid, ibus.ireq_addr); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'hbfc0_0200;
        tick();  // redirect beats the pending AdEL capture
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || ibus.ireq_valid !== 1'b1 || ibus.ireq_addr !== 32'hbfc0_0200)
            begin errors++; $display("FAIL mis_redirect: got ov=%b v=%b addr=%h want ov=0 v=1 addr=bfc00200", out_valid, ibus.ireq_valid, ibus.ireq_addr); end
    endtask

    task automatic test_redirect_req;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hbfc0_0300;
        tick();  // REQ without addr_ok -> DROP_REQ
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (ibus.ireq_valid !== 1'b1 || ibus.ireq_addr !== 32'hbfc0_0200)
                begin errors++; $display("FAIL rr_held_%0d: got v=%b addr=%h want v=1 addr=bfc00200", i, ibus.ireq_valid, ibus.ireq_addr); end
            if (i == 0) tick();
        end
        bus(1'b1, 1'b0, '0);
        tick();  // DROP_REQ -> DROP_WAIT
        checks++; if (ibus.ireq_valid !== 1'b0) begin errors++; $display("FAIL rr_drop_wait: got %b want 0", ibus.ireq_valid); end
        bus(1'b0, 1'b1, 32'hbad0_bad0);
        tick();  // dropped -> REQ at target
        bus(1'b0, 1'b0, '0);
        checks++; if (out_valid !== 1'b0 || ibus.ireq_addr !== 32'hbfc0_0300 || ibus.ireq_valid !== 1'b1)
            begin errors++; $display("FAIL rr_target: got ov=%b v=%b addr=%h want ov=0 v=1 addr=bfc00300", out_valid, ibus.ireq_valid, ibus.ireq_addr); end
        bus(1'b1, 1'b1, 32'h2222_2222);
        tick();
        bus(1'b0, 1'b0, '0);
        checks++; if (out_pc !== 32'hbfc0_0300 || out_instr !== 32'h2222_2222)
            begin errors++; $display("FAIL rr_target_out: got pc=%h instr=%h want pc=bfc00300 instr=22222222", out_pc, out_instr); end
    endtask

    task automatic test_reset_in_wait;
        tick();  // HOLD -> REQ at bfc00304
        bus(1'b1, 1'b0, '0);
        tick();  // -> WAIT
        bus(1'b0, 1'b0, '0);
        #2;
        resetn = 1'b0;
        #1;  // still between clock edges
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin errors++; $display("FAIL async_reset_out: got v=%b pc=%h want v=0 pc=00000000", out_valid, out_pc); end
        checks++; if (ibus.ireq_addr !== 32'hbfc0_0000 || ibus.ireq_valid !== 1'b1)
            begin errors++; $display("FAIL async_reset_req: got v=%b addr=%h want v=1 addr=bfc00000", ibus.ireq_valid, ibus.ireq_addr); end
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_wrap_and_hold_redirect;
        bus(1'b1, 1'b1, '0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hffff_fffc;
        tick();
        redirect_valid = 1'b0;
        bus(1'b1, 1'b1, 32'h3333_3333);
        tick();
        bus(1'b0, 1'b0, '0);
        checks++; if (out_pc !== 32'hffff_fffc || out_instr !== 32'h3333_3333)
            begin errors++; $display("FAIL wrap_out: got pc=%h instr=%h want pc=fffffffc instr=33333333", out_pc, out_instr); end
        tick();
        checks++; if (ibus.ireq_addr !== 32'h0 || ibus.ireq_valid !== 1'b1)
            begin errors++; $display("FAIL wrap_next: got v=%b addr=%h want v=1 addr=00000000", ibus.ireq_valid, ibus.ireq_addr); end
        bus(1'b1, 1'b1, 32'h4444_4444);
        stall = 1'b1;
        tick();  // HOLD at 0
        bus(1'b0, 1'b0, '0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hbfc0_0400;
        tick();  // redirect overrides stalled HOLD
        redirect_valid = 1'b0;
        stall          = 1'b0;
        checks++; if (out_valid !== 1'b0 || ibus.ireq_addr !== 32'hbfc0_0400 || ibus.ireq_valid !== 1'b1)
            begin errors++; $display("FAIL hold_redirect: got ov=%b v=%b addr=%h want ov=0 v=1 addr=bfc00400", out_valid, ibus.ireq_valid, ibus.ireq_addr); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_wait();
        test_misaligned();
        test_redirect_req();
        test_reset_in_wait();
        test_wrap_and_hold_redirect();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete within 50000 time units");
        $fatal(1, "timeout");
    end

endmodule
